lab2_proc_imem_resp_drop_queue: RTL and testbench
=================================================

// Module: lab2_proc_imem_resp_drop_queue
// PURPOSE
//  Sits between the instruction memory response port and the F/D pipeline register of the
//  processor datapath. Buffers fetched instruction words in a small FIFO and tracks
//  outstanding imem requests. On a control redirect (squash), it flushes the FIFO and drops
//  the responses of every request issued before the redirect, so D only sees valid-path insts.
// PARAMETERS
//  p_depth         2   FIFO entries (power of two, >=2)
//  p_max_inflight  4   max outstanding imem requests; sets counter width clog2(p_max_inflight+1)
// PORTS
//  clk               in   1   clock; all state updates on rising edge
//  reset             in   1   synchronous, active-low reset (reset==0 resets)
//  imemreq_val       in   1   F stage issuing an imem request
//  imemreq_rdy       out  1   request may issue (outstanding < p_max_inflight)
//  imemresp_val      in   1   memory response valid
//  imemresp_rdy      out  1   response accepted (buffered or dropped)
//  imemresp_data     in   32  instruction word
//  squash            in   1   redirect from ctrl (branch/jump taken); one-cycle pulse
//  deq_val           out  1   FIFO head valid to D stage
//  deq_rdy           in   1   D stage takes head (reg_en_D)
//  deq_data          out  32  FIFO head instruction word
//  num_outstanding   out  clog2(p_max_inflight+1)  requests issued, response not yet seen
//  num_dropped       out  32  saturating count of dropped responses (stats)
// BEHAVIOUR
//  - Fires: req_go=imemreq_val&imemreq_rdy; resp_go=imemresp_val&imemresp_rdy; deq_go=deq_val&deq_rdy.
//  - Reset (reset==0): FIFO empty, head/tail pointers 0, num_outstanding=0, drop_cnt=0,
//    num_dropped=0; deq_val=0, deq_data=0, imemreq_rdy=1, imemresp_rdy=1.
//  - Outputs are registered-state functions only; no comb path from imemresp_* to deq_*
//    (min one-cycle latency response->deq_val). imemreq_rdy = (num_outstanding < p_max_inflight).
//  - imemresp_rdy = (drop_cnt != 0) | !full. Full counted by occupancy, not pointer compare.
//  - num_outstanding' = num_outstanding + req_go - resp_go (no wrap; both at max is net 0).
//  - Drop mode (drop_cnt!=0): resp_go decrements drop_cnt, data discarded, num_dropped+1
//    (saturates at 32'hFFFFFFFF); FIFO unaffected.
//  - Normal mode: resp_go enqueues imemresp_data at tail; deq_go pops head; both same cycle
//    allowed at any occupancy (incl. full: rdy only if not full, so pop-then-push on full is
//    NOT allowed -- no bypass, no pipelined enq).
//  - squash cycle: FIFO cleared next cycle (occupancy=0, pointers 0); deq_go in the same
//    cycle still completes (D took that word); drop_cnt' = num_outstanding - resp_go;
//    a resp_go in the squash cycle is discarded (counted in num_dropped) regardless of mode;
//    a req_go in the squash cycle is the redirect-target fetch: counted in num_outstanding,
//    NOT added to drop_cnt. Squash while already in drop mode overwrites drop_cnt per rule.
//  - States: NORMAL (drop_cnt==0) / DROP (drop_cnt>0); DROP->NORMAL when last dropped resp
//    fires; NORMAL->DROP on squash with outstanding>resp_go; else stay NORMAL.
//  - Invariant (assert): drop_cnt <= num_outstanding; resp_go with num_outstanding==0 is an
//    error (assertion only; counter held at 0).
//  - Reset mid-operation: all state discarded at that edge, late responses after reset are
//    outside contract.
// TESTING
//  1 Reset 2 cycles, 3 req/resp pairs of 0x00000013,0x00100093,0x00200113 with deq_rdy=1 ->
//    same words on deq_data in order, each 1 cycle after resp, num_outstanding back to 0.
//  2 deq_rdy=0, 3 responses, p_depth=2 -> 2 buffered, imemresp_rdy=0 on 3rd until one deq;
//    order preserved; 4 reqs outstanding -> imemreq_rdy=0.
//  3 2 outstanding, FIFO holds 1 word, squash + req_go same cycle -> deq_val=0 next cycle,
//    drop_cnt=2; next 2 responses dropped (num_dropped=2), 3rd response (0xDEADBEEF) dequeued.
//  4 squash coincident with resp_go and deq_go, 3 outstanding -> deq completes, resp dropped,
//    drop_cnt=2, num_dropped=1.
//  5 squash during DROP with drop_cnt=1, outstanding=3 -> drop_cnt=3; exactly 3 later drops.
//  6 reset asserted while in DROP with full FIFO -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/lab2_proc_imem_resp_drop_queue.sv
// Imem response queue between F and D: buffers fetched words and drops
// responses belonging to requests issued before a control redirect.
module lab2_proc_imem_resp_drop_queue #(
    parameter int p_depth        = 2,
    parameter int p_max_inflight = 4,
    localparam int c_cnt_w       = $clog2(p_max_inflight + 1)
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               imemreq_val,
    output logic               imemreq_rdy,

    input  logic               imemresp_val,
    output logic               imemresp_rdy,
    input  logic [31:0]        imemresp_data,

    input  logic               squash,

    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [31:0]        deq_data,

    output logic [c_cnt_w-1:0] num_outstanding,
    output logic [31:0]        num_dropped
);

    localparam int c_ptr_w = $clog2(p_depth);
    localparam int c_occ_w = $clog2(p_depth + 1);

    localparam logic [c_cnt_w-1:0] c_max  = c_cnt_w'(p_max_inflight);
    localparam logic [c_occ_w-1:0] c_full = c_occ_w'(p_depth);

    typedef enum logic {
        NORMAL = 1'b0,
        DROP   = 1'b1
    } state_t;

    state_t             state;
    logic [31:0]        mem [p_depth];
    logic [c_ptr_w-1:0] head;
    logic [c_ptr_w-1:0] tail;
    logic [c_occ_w-1:0] occ;
    logic [c_cnt_w-1:0] outstanding;
    logic [c_cnt_w-1:0] drop_cnt;
    logic [31:0]        dropped;

    logic               full;
    logic               req_go;
    logic               resp_go;
    logic               deq_go;
    logic               drop_now;
    logic               enq;
    logic [c_cnt_w-1:0] out_next;
    logic [c_cnt_w-1:0] drop_next;
    logic [c_occ_w-1:0] occ_next;

    assign full         = (occ == c_full);
    assign imemreq_rdy  = (outstanding < c_max);
    assign imemresp_rdy = (state == DROP) || !full;
    assign deq_val      = (occ != '0);
    assign deq_data     = deq_val ? mem[head] : '0;

    assign num_outstanding = outstanding;
    assign num_dropped     = dropped;

    assign req_go  = imemreq_val && imemreq_rdy;
    assign resp_go = imemresp_val && imemresp_rdy;
    assign deq_go  = deq_val && deq_rdy;

    // A response landing in the squash cycle is stale even in NORMAL mode.
    assign drop_now = resp_go && (squash || (state == DROP));
    assign enq      = resp_go && !drop_now;

    always_comb begin
        out_next = outstanding;
        if (req_go && !resp_go) begin
            out_next = outstanding + c_cnt_w'(1);
        end else if (!req_go && resp_go && (outstanding != '0)) begin
            out_next = outstanding - c_cnt_w'(1);
        end
    end

    // The redirect-target fetch issued with squash is never dropped.
    always_comb begin
        drop_next = drop_cnt;
        if (squash) begin
            if (resp_go && (outstanding != '0)) begin
                drop_next = outstanding - c_cnt_w'(1);
            end else begin
                drop_next = outstanding;
            end
        end else if (drop_now && (drop_cnt != '0)) begin
            drop_next = drop_cnt - c_cnt_w'(1);
        end
    end

    always_comb begin
        occ_next = occ;
        if (squash) begin
            occ_next = '0;
        end else if (enq && !deq_go) begin
            occ_next = occ + c_occ_w'(1);
        end else if (!enq && deq_go) begin
            occ_next = occ - c_occ_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= NORMAL;
            head        <= '0;
            tail        <= '0;
            occ         <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            dropped     <= '0;
        end else begin
            state       <= (drop_next != '0) ? DROP : NORMAL;
            outstanding <= out_next;
            drop_cnt    <= drop_next;
            occ         <= occ_next;
            if (drop_now && (dropped != '1)) begin
                dropped <= dropped + 32'd1;
            end
            if (squash) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (enq) begin
                    tail <= tail + c_ptr_w'(1);
                end
                if (deq_go) begin
                    head <= head + c_ptr_w'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !squash) begin
            mem[tail] <= imemresp_data;
        end
    end

    a_drop_le_out : assert property (
        @(posedge clk) disable iff (!reset)
        drop_cnt <= outstanding
    );

    a_no_orphan_resp : assert property (
        @(posedge clk) disable iff (!reset)
        resp_go |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_lab2_proc_imem_resp_drop_queue.sv
// Scoreboard bench: stimulus pushes expected words, a monitor pops them
// on every dequeue; counters and ready flags are checked directly.
module tb_lab2_proc_imem_resp_drop_queue;

    logic        clk;
    logic        reset;
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic        imemresp_val;
    logic        imemresp_rdy;
    logic [31:0] imemresp_data;
    logic        squash;
    logic        deq_val;
    logic        deq_rdy;
    logic [31:0] deq_data;
    logic [2:0]  num_outstanding;
    logic [31:0] num_dropped;

    int          checks;
    int          errors;
    logic [31:0] exp_q [$];
    logic [31:0] base;

    lab2_proc_imem_resp_drop_queue #(
        .p_depth        (2),
        .p_max_inflight (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imemreq_val     (imemreq_val),
        .imemreq_rdy     (imemreq_rdy),
        .imemresp_val    (imemresp_val),
        .imemresp_rdy    (imemresp_rdy),
        .imemresp_data   (imemresp_data),
        .squash          (squash),
        .deq_val         (deq_val),
        .deq_rdy         (deq_rdy),
        .deq_data        (deq_data),
        .num_outstanding (num_outstanding),
        .num_dropped     (num_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && deq_val && deq_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deq_unexpected got %h expected none", deq_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (deq_data !== e) begin
                    errors++;
                    $display("FAIL deq_data got %h expected %h", deq_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req();
        imemreq_val = 1'b1;
        step();
        imemreq_val = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d, input bit kept);
        check("resp_rdy", 32'(imemresp_rdy), 32'd1);
        imemresp_val  = 1'b1;
        imemresp_data = d;
        if (kept) exp_q.push_back(d);
        step();
        imemresp_val  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_deq_val"}, 32'(deq_val), 32'd0);
        check({tag, "_deq_data"}, deq_data, 32'd0);
        check({tag, "_req_rdy"}, 32'(imemreq_rdy), 32'd1);
        check({tag, "_resp_rdy"}, 32'(imemresp_rdy), 32'd1);
        check({tag, "_outst"}, 32'(num_outstanding), 32'd0);
        check({tag, "_dropped"}, num_dropped, 32'd0);
    endtask

    initial begin
        logic [31:0] w [3];
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        imemreq_val   = 1'b0;
        imemresp_val  = 1'b0;
        imemresp_data = '0;
        squash        = 1'b0;
        deq_rdy       = 1'b1;
        w[0] = 32'h0000_0013;
        w[1] = 32'h0010_0093;
        w[2] = 32'h0020_0113;

        do_reset();
        check_reset_outputs("rst");

        // 1: simple req/resp pairs, one-cycle latency to deq
        for (int i = 0; i < 3; i++) begin
            req();
            check("t1_outst_req", 32'(num_outstanding), 32'd1);
            resp(w[i], 1'b1);
            check("t1_deq_val", 32'(deq_val), 32'd1);
            check("t1_deq_data", deq_data, w[i]);
            check("t1_outst_resp", 32'(num_outstanding), 32'd0);
            step();
            check("t1_deq_empty", 32'(deq_val), 32'd0);
        end

        // 2: backpressure, full FIFO, inflight limit
        deq_rdy = 1'b0;
        for (int i = 0; i < 4; i++) req();
        check("t2_outst4", 32'(num_outstanding), 32'd4);
        check("t2_req_rdy0", 32'(imemreq_rdy), 32'd0);
        req();
        check("t2_outst_hold", 32'(num_outstanding), 32'd4);
        resp(32'hA000_0000, 1'b1);
        resp(32'hA000_0001, 1'b1);
        check("t2_resp_rdy_full", 32'(imemresp_rdy), 32'd0);
        imemresp_val  = 1'b1;
        imemresp_data = 32'hA000_0002;
        step();
        check("t2_resp_stall", 32'(imemresp_rdy), 32'd0);
        check("t2_outst2", 32'(num_outstanding), 32'd2);
        deq_rdy = 1'b1;
        step();
        deq_rdy = 1'b0;
        check("t2_resp_rdy_room", 32'(imemresp_rdy), 32'd1);
        exp_q.push_back(32'hA000_0002);
        step();
        imemresp_val = 1'b0;
        check("t2_outst1", 32'(num_outstanding), 32'd1);
        deq_rdy = 1'b1;
        step();
        step();
        resp(32'hA000_0003, 1'b1);
        step();
        check("t2_outst0", 32'(num_outstanding), 32'd0);
        check("t2_drained", 32'(deq_val), 32'd0);

        // 3: squash with buffered word and same-cycle redirect fetch
        base = num_dropped;
        deq_rdy = 1'b0;
        req();
        req();
        req();
        resp(32'hB000_0000, 1'b1);
        squash      = 1'b1;
        imemreq_val = 1'b1;
        step();
        squash      = 1'b0;
        imemreq_val = 1'b0;
        exp_q.delete();
        check("t3_flushed", 32'(deq_val), 32'd0);
        check("t3_outst3", 32'(num_outstanding), 32'd3);
        resp(32'hC000_0000, 1'b0);
        resp(32'hC000_0001, 1'b0);
        check("t3_dropped2", num_dropped - base, 32'd2);
        check("t3_nodeq", 32'(deq_val), 32'd0);
        resp(32'hDEAD_BEEF, 1'b1);
        check("t3_deq_val", 32'(deq_val), 32'd1);
        check("t3_deq_data", deq_data, 32'hDEAD_BEEF);
        deq_rdy = 1'b1;
        step();
        check("t3_outst0", 32'(num_outstanding), 32'd0);

        // 4: squash coincident with resp_go and deq_go
        base = num_dropped;
        deq_rdy = 1'b0;
        for (int i = 0; i < 4; i++) req();
        resp(32'hE000_0000, 1'b1);
        squash        = 1'b1;
        imemresp_val  = 1'b1;
        imemresp_data = 32'hE000_0001;
        deq_rdy       = 1'b1;
        step();
        squash       = 1'b0;
        imemresp_val = 1'b0;
        exp_q.delete();
        check("t4_dropped1", num_dropped - base, 32'd1);
        check("t4_outst2", 32'(num_outstanding), 32'd2);
        check("t4_flushed", 32'(deq_val), 32'd0);
        resp(32'hE000_0002, 1'b0);
        resp(32'hE000_0003, 1'b0);
        check("t4_dropped3", num_dropped - base, 32'd3);
        check("t4_outst0", 32'(num_outstanding), 32'd0);
        check("t4_nodeq", 32'(deq_val), 32'd0);

        // 5: squash while already dropping overwrites drop_cnt
        base = num_dropped;
        req();
        req();
        squash = 1'b1;
        step();
        squash = 1'b0;
        resp(32'hF000_0000, 1'b0);
        req();
        req();
        check("t5_outst3", 32'(num_outstanding), 32'd3);
        squash = 1'b1;
        step();
        squash = 1'b0;
        for (int i = 0; i < 3; i++) resp(32'hF100_0000 + 32'(i), 1'b0);
        check("t5_dropped4", num_dropped - base, 32'd4);
        check("t5_nodeq", 32'(deq_val), 32'd0);
        req();
        resp(32'hF000_00F0, 1'b1);
        check("t5_deq_val", 32'(deq_val), 32'd1);
        check("t5_deq_data", deq_data, 32'hF000_00F0);
        step();
        check("t5_outst0", 32'(num_outstanding), 32'd0);

        // 6: reset mid-operation, full FIFO then DROP mode
        deq_rdy = 1'b0;
        for (int i = 0; i < 4; i++) req();
        resp(32'h6000_0000, 1'b1);
        resp(32'h6000_0001, 1'b1);
        check("t6_full", 32'(imemresp_rdy), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        step();
        check_reset_outputs("t6a");
        reset = 1'b1;
        req();
        req();
        squash = 1'b1;
        step();
        squash = 1'b0;
        reset  = 1'b0;
        step();
        check_reset_outputs("t6b");
        reset   = 1'b1;
        deq_rdy = 1'b1;
        req();
        resp(32'h6000_00AA, 1'b1);
        check("t6_deq_val", 32'(deq_val), 32'd1);
        check("t6_deq_data", deq_data, 32'h6000_00AA);
        check("t6_dropped0", num_dropped, 32'd0);
        step();
        step();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
